// File: rtl/iram_loader_ram.sv
// iram_loader_ram -- instruction RAM for the matrix-multiplier processor.
//
// Purpose:
//   DEPTH = 2**ADDR_W words of DATA_W bits. The processor port is single-clock
//   with RD_LAT (1 or 2) cycles of read latency and a q_valid strobe. Reads are
//   read-first, so a same-cycle write to the same address returns the old word.
//   A streaming loader (valid/ready) fills a contiguous, wrapping region while
//   the processor port is stalled.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   address/data/wren/rden  processor access (ignored while load_busy)
//   q/q_valid/q_perr      read data, completion strobe, parity error flag
//   cpu_stall             processor accesses are being ignored (= load_busy)
//   load_start/base/len   start a bulk load (sampled in IDLE only)
//   load_data/load_valid  stream input; load_ready is the accept handshake
//   load_busy/load_done   loader active / one-cycle completion pulse
//   perr_inject           store inverted parity on this cycle's write
//
// Optional feature: define IRAM_PARITY_EN to store an even-parity bit per
// word and report mismatches on q_perr. Without it q_perr is tied low and
// perr_inject is ignored.

module iram_loader_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    input  logic              wren,
    input  logic              rden,
    output logic [DATA_W-1:0] q,
    output logic              q_valid,
    output logic              q_perr,
    output logic              cpu_stall,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W:0]   load_len,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_valid,
    output logic              load_ready,
    output logic              load_busy,
    output logic              load_done,
    input  logic              perr_inject
);

    localparam int unsigned     DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
`ifdef IRAM_PARITY_EN
    localparam int unsigned MEM_W = DATA_W + 1;
`else
    localparam int unsigned MEM_W = DATA_W;
`endif

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    logic [MEM_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;

    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_data_q, s1_data_d;
    logic              s1_perr_q, s1_perr_d;

    logic              ld_accept, cpu_wr, mem_we, rd_fire, rd_perr;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [MEM_W-1:0]  wword, rd_word;

    // Write port: loader and processor never collide since the processor is
    // locked out whenever the loader can accept.
    always_comb begin
        ld_accept = load_valid && ready_q && !reset;
        cpu_wr    = wren && !busy_q && !reset;
        mem_we    = ld_accept || cpu_wr;
        waddr     = ld_accept ? ptr_q : address;
        wdata     = ld_accept ? load_data : data;
    end

`ifdef IRAM_PARITY_EN
    // Even parity: XOR over the whole stored word is 0 for a clean word.
    assign wword   = {(^wdata) ^ perr_inject, wdata};
    assign rd_perr = ^rd_word;
`else
    logic unused_perr_inject;
    assign unused_perr_inject = perr_inject;
    assign wword   = wdata;
    assign rd_perr = 1'b0;
`endif

    assign rd_word = mem[address];
    assign rd_fire = rden && !busy_q;

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[waddr] <= wword;
        end
    end

    // Loader next-state
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    if (load_len != '0) begin
                        ptr_d   = load_base;
                        cnt_d   = (load_len > DEPTH_CNT) ? DEPTH_CNT : load_len;
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_LOAD: begin
                if (ld_accept) begin
                    ptr_d = ptr_q + 1'b1;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == (ADDR_W+1)'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d  = (state_d == S_LOAD);
        ready_d = (state_d == S_LOAD);
        done_d  = (state_d == S_DONE);
    end

    // First read stage: data and parity flag hold when no read is issued.
    always_comb begin
        s1_valid_d = rd_fire;
        s1_data_d  = rd_fire ? rd_word[DATA_W-1:0] : s1_data_q;
        s1_perr_d  = rd_fire ? rd_perr : s1_perr_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_perr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_perr_q  <= s1_perr_d;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              s2_valid_q, s2_valid_d;
            logic [DATA_W-1:0] s2_data_q, s2_data_d;
            logic              s2_perr_q, s2_perr_d;

            always_comb begin
                s2_valid_d = s1_valid_q;
                s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
                s2_perr_d  = s1_valid_q ? s1_perr_q : s2_perr_q;
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    s2_valid_q <= 1'b0;
                    s2_data_q  <= '0;
                    s2_perr_q  <= 1'b0;
                end else begin
                    s2_valid_q <= s2_valid_d;
                    s2_data_q  <= s2_data_d;
                    s2_perr_q  <= s2_perr_d;
                end
            end

            assign q       = s2_data_q;
            assign q_valid = s2_valid_q;
            assign q_perr  = s2_perr_q;
        end else begin : g_lat1
            assign q       = s1_data_q;
            assign q_valid = s1_valid_q;
            assign q_perr  = s1_perr_q;
        end
    endgenerate

    assign load_busy  = busy_q;
    assign load_ready = ready_q;
    assign load_done  = done_q;
    assign cpu_stall  = busy_q;

endmodule

// File: tb/tb_iram_loader_ram.sv
`timescale 1ns/1ps
module tb_iram_loader_ram;

    localparam int DW = 8;
    localparam int AW = 8;
`ifdef IRAM_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, wren, rden, load_start, load_valid, perr_inject;
    logic [AW-1:0] address, load_base;
    logic [DW-1:0] data, load_data;
    logic [AW:0]   load_len;

    logic [DW-1:0] q1, q2;
    logic qv1, qp1, st1, lr1, lb1, ld1;
    logic qv2, qp2, st2, lr2, lb2, ld2;

    iram_loader_ram #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) dut1 (
        .clock(clk), .reset(reset), .address(address), .data(data),
        .wren(wren), .rden(rden), .q(q1), .q_valid(qv1), .q_perr(qp1),
        .cpu_stall(st1), .load_start(load_start), .load_base(load_base),
        .load_len(load_len), .load_data(load_data), .load_valid(load_valid),
        .load_ready(lr1), .load_busy(lb1), .load_done(ld1),
        .perr_inject(perr_inject)
    );

    iram_loader_ram #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2)) dut2 (
        .clock(clk), .reset(reset), .address(address), .data(data),
        .wren(wren), .rden(rden), .q(q2), .q_valid(qv2), .q_perr(qp2),
        .cpu_stall(st2), .load_start(load_start), .load_base(load_base),
        .load_len(load_len), .load_data(load_data), .load_valid(load_valid),
        .load_ready(lr2), .load_busy(lb2), .load_done(ld2),
        .perr_inject(perr_inject)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: word array plus a per-word "bad parity" flag, the
    // loader as a remaining-word count, and the last read result per latency.
    bit [7:0] m_mem [256];
    bit       m_bad [256];
    bit       m_busy, m_done;
    bit [7:0] m_ptr;
    int       m_rem;
    bit [7:0] e_q1, e_q2, pend_q;
    bit       e_v1, e_v2, e_p1, e_p2, pend_v, pend_p;

    task automatic idle_inputs();
        wren = 0; rden = 0; address = '0; data = '0; perr_inject = 0;
        load_start = 0; load_base = '0; load_len = '0; load_data = '0; load_valid = 0;
    endtask

    // One clock: model the edge from current inputs, then compare everything.
    task automatic step();
        bit       rd_now;
        bit [7:0] rd_q;
        bit       rd_p;
        if (reset) begin
            m_busy = 0; m_done = 0; pend_v = 0;
            e_q1 = 0; e_q2 = 0; e_v1 = 0; e_v2 = 0; e_p1 = 0; e_p2 = 0;
        end else begin
            rd_now = rden && !m_busy;
            rd_q   = m_mem[address];
            rd_p   = PAR && m_bad[address];
            e_v2 = pend_v;
            if (pend_v) begin e_q2 = pend_q; e_p2 = pend_p; end
            pend_v = rd_now; pend_q = rd_q; pend_p = rd_p;
            e_v1 = rd_now;
            if (rd_now) begin e_q1 = rd_q; e_p1 = rd_p; end
            if (m_busy) begin
                if (load_valid) begin
                    m_mem[m_ptr] = load_data;
                    m_bad[m_ptr] = perr_inject;
                    m_ptr++;
                    m_rem--;
                    if (m_rem == 0) begin m_busy = 0; m_done = 1; end
                end
            end else begin
                if (wren) begin
                    m_mem[address] = data;
                    m_bad[address] = perr_inject;
                end
                if (m_done) m_done = 0;
                else if (load_start) begin
                    if (load_len == 0) m_done = 1;
                    else begin
                        m_busy = 1;
                        m_ptr  = load_base;
                        m_rem  = (int'(load_len) > 256) ? 256 : int'(load_len);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        chk("dut1.q", q1, e_q1);     chk("dut1.q_valid", qv1, e_v1);
        chk("dut1.q_perr", qp1, e_p1);
        chk("dut2.q", q2, e_q2);     chk("dut2.q_valid", qv2, e_v2);
        chk("dut2.q_perr", qp2, e_p2);
        chk("dut1.load_busy", lb1, m_busy); chk("dut1.load_ready", lr1, m_busy);
        chk("dut1.load_done", ld1, m_done); chk("dut1.cpu_stall", st1, m_busy);
        chk("dut2.load_busy", lb2, m_busy); chk("dut2.load_ready", lr2, m_busy);
        chk("dut2.load_done", ld2, m_done); chk("dut2.cpu_stall", st2, m_busy);
    endtask

    // Read one address and compare both latencies against a constant.
    task automatic read_expect(input string name, input logic [7:0] a, input logic [7:0] exp);
        rden = 1; address = a;
        step();
        chk({name, ".lat1"}, {qv1, q1}, {1'b1, exp});
        rden = 0;
        step();
        chk({name, ".lat2"}, {qv2, q2}, {1'b1, exp});
    endtask

    typedef struct {
        logic       wr, rd, inj;
        logic [7:0] addr, wd;
        logic       v1;
        logic [7:0] q1;
        logic       p1, v2;
        logic [7:0] q2;
        logic       p2;
    } vec_t;

    function automatic vec_t mk(logic wr, logic rd, logic inj, logic [7:0] addr, logic [7:0] wd,
                                logic v1, logic [7:0] eq1, logic p1,
                                logic v2, logic [7:0] eq2, logic p2);
        vec_t v;
        v.wr = wr; v.rd = rd; v.inj = inj; v.addr = addr; v.wd = wd;
        v.v1 = v1; v.q1 = eq1; v.p1 = p1; v.v2 = v2; v.q2 = eq2; v.p2 = p2;
        return v;
    endfunction

    vec_t tbl [14];

    initial begin
        logic [7:0] keep40, keep82, keep83, keep84;
        int acc, guard;

        //            wr rd inj addr   wd     | v1 q1    p1  | v2 q2    p2
        tbl[0]  = mk(1, 0, 0, 8'h10, 8'hA5,  0, 8'h00, 0,   0, 8'h00, 0);
        tbl[1]  = mk(0, 1, 0, 8'h10, 8'h00,  1, 8'hA5, 0,   0, 8'h00, 0);
        tbl[2]  = mk(0, 0, 0, 8'h00, 8'h00,  0, 8'hA5, 0,   1, 8'hA5, 0);
        tbl[3]  = mk(0, 0, 0, 8'h00, 8'h00,  0, 8'hA5, 0,   0, 8'hA5, 0);
        tbl[4]  = mk(1, 0, 0, 8'h20, 8'h11,  0, 8'hA5, 0,   0, 8'hA5, 0);
        tbl[5]  = mk(1, 1, 0, 8'h20, 8'h22,  1, 8'h11, 0,   0, 8'hA5, 0);
        tbl[6]  = mk(0, 1, 0, 8'h20, 8'h00,  1, 8'h22, 0,   1, 8'h11, 0);
        tbl[7]  = mk(1, 0, 1, 8'h30, 8'h3C,  0, 8'h22, 0,   1, 8'h22, 0);
        tbl[8]  = mk(0, 1, 0, 8'h30, 8'h00,  1, 8'h3C, PAR, 0, 8'h22, 0);
        tbl[9]  = mk(0, 1, 0, 8'h20, 8'h00,  1, 8'h22, 0,   1, 8'h3C, PAR);
        tbl[10] = mk(0, 0, 0, 8'h00, 8'h00,  0, 8'h22, 0,   1, 8'h22, 0);
        tbl[11] = mk(1, 0, 0, 8'h31, 8'h5A,  0, 8'h22, 0,   0, 8'h22, 0);
        tbl[12] = mk(0, 1, 0, 8'h31, 8'h00,  1, 8'h5A, 0,   0, 8'h22, 0);
        tbl[13] = mk(0, 0, 0, 8'h00, 8'h00,  0, 8'h5A, 0,   1, 8'h5A, 0);

        idle_inputs();
        reset = 1;
        step();
        step();
        reset = 0;

        for (int i = 0; i < 14; i++) begin
            wren = tbl[i].wr; rden = tbl[i].rd; perr_inject = tbl[i].inj;
            address = tbl[i].addr; data = tbl[i].wd;
            step();
            chk($sformatf("tbl%0d.v1", i), qv1, tbl[i].v1);
            chk($sformatf("tbl%0d.q1", i), q1, tbl[i].q1);
            chk($sformatf("tbl%0d.p1", i), qp1, tbl[i].p1);
            chk($sformatf("tbl%0d.v2", i), qv2, tbl[i].v2);
            chk($sformatf("tbl%0d.q2", i), q2, tbl[i].q2);
            chk($sformatf("tbl%0d.p2", i), qp2, tbl[i].p2);
        end
        idle_inputs();

        // Give every word a defined value.
        for (int a = 0; a < 256; a++) begin
            wren = 1; address = 8'(a); data = 8'($urandom);
            step();
        end
        idle_inputs();
        keep40 = m_mem[8'h40];

        // Wrapping load FE..01 with a gap on the second word; processor
        // write/read attempted during the gap.
        load_start = 1; load_base = 8'hFE; load_len = 9'd4;
        step();
        load_start = 0;
        load_valid = 1; load_data = 8'd1; step();
        load_valid = 0; wren = 1; rden = 1; address = 8'h40; data = 8'h77;
        step();
        chk("stall.cpu_stall", st1, 1'b1);
        chk("stall.no_q_valid", qv1, 1'b0);
        wren = 0; rden = 0;
        load_valid = 1; load_data = 8'd2; step();
        load_data = 8'd3; step();
        load_data = 8'd4; step();
        chk("load4.done", ld1, 1'b1);
        chk("load4.busy", lb1, 1'b0);
        load_valid = 0;
        step();
        chk("load4.done_single", ld1, 1'b0);
        read_expect("wrap_fe", 8'hFE, 8'd1);
        read_expect("wrap_ff", 8'hFF, 8'd2);
        read_expect("wrap_00", 8'h00, 8'd3);
        read_expect("wrap_01", 8'h01, 8'd4);
        read_expect("stalled_wr", 8'h40, keep40);

        // Zero-length load: done next cycle, nothing written.
        load_start = 1; load_len = 9'd0; load_base = 8'h40;
        step();
        chk("len0.done", ld1, 1'b1);
        chk("len0.busy", lb1, 1'b0);
        load_start = 0;
        step();
        chk("len0.done_single", ld1, 1'b0);

        // Reset after 2 of 5 words.
        keep82 = m_mem[8'h82]; keep83 = m_mem[8'h83]; keep84 = m_mem[8'h84];
        load_start = 1; load_base = 8'h80; load_len = 9'd5;
        step();
        load_start = 0;
        load_valid = 1; load_data = 8'hA0; step();
        load_data = 8'hA1; step();
        reset = 1; load_data = 8'hA2; step();
        chk("rst_mid.busy", lb1, 1'b0);
        chk("rst_mid.ready", lr1, 1'b0);
        reset = 0; load_valid = 0;
        read_expect("rst_mid_80", 8'h80, 8'hA0);
        read_expect("rst_mid_81", 8'h81, 8'hA1);
        read_expect("rst_mid_82", 8'h82, keep82);
        read_expect("rst_mid_83", 8'h83, keep83);
        read_expect("rst_mid_84", 8'h84, keep84);
        load_start = 1; load_base = 8'h90; load_len = 9'd1;
        step();
        chk("restart.busy", lb1, 1'b1);
        load_start = 0; load_valid = 1; load_data = 8'h5C;
        step();
        chk("restart.done", ld1, 1'b1);
        load_valid = 0;
        step();
        read_expect("restart_90", 8'h90, 8'h5C);

        // Length beyond DEPTH is clamped to a full 256-word pass.
        load_start = 1; load_base = 8'h00; load_len = 9'd300;
        step();
        load_start = 0;
        acc = 0; guard = 0;
        while (acc < 256 && guard < 2000) begin
            load_valid = ($urandom_range(0, 3) != 0);
            load_data  = 8'(acc * 3 + 7);
            step();
            if (load_valid) acc++;
            guard++;
        end
        chk("clamp.no_timeout", guard < 2000, 1'b1);
        chk("clamp.done", ld1, 1'b1);
        chk("clamp.busy", lb1, 1'b0);
        load_valid = 0;
        step();
        read_expect("clamp_00", 8'h00, 8'd7);
        read_expect("clamp_ff", 8'hFF, 8'(255 * 3 + 7));

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            reset       = ($urandom_range(0, 199) == 0);
            rden        = $urandom_range(0, 1) != 0;
            wren        = ($urandom_range(0, 2) == 0);
            address     = 8'($urandom);
            data        = 8'($urandom);
            perr_inject = ($urandom_range(0, 7) == 0);
            load_start  = ($urandom_range(0, 19) == 0);
            load_base   = 8'($urandom);
            load_len    = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(0, 300))
                                                      : 9'($urandom_range(0, 6));
            load_valid  = ($urandom_range(0, 2) != 0);
            load_data   = 8'($urandom);
            step();
        end
        reset = 0;
        idle_inputs();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule

// File: doc/iram_loader_ram.md
Name: iram_loader_ram

Overview:
Parametrised instruction RAM for the matrix-multiplier processor, successor to the 8x256 IRAM. It has a single-clock processor port with configurable read latency and a `q_valid` strobe. A second port is a streaming loader: a valid/ready bulk-write path that fills a contiguous region from a host or DMA while the processor is stalled. It sits between the instruction fetch stage and the program-load path.

Parameters:
DATA_W, 8, instruction word width in bits
ADDR_W, 8, address width; DEPTH = 2**ADDR_W words
RD_LAT, 1, read latency in clock edges; legal values 1 or 2; 2 adds an output register stage

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
address  input  ADDR_W  processor read/write address
data  input  DATA_W  processor write data
wren  input  1  processor write enable
rden  input  1  processor read enable
q  output  DATA_W  read data
q_valid  output  1  one-cycle strobe: q carries data for a read issued RD_LAT edges earlier
q_perr  output  1  parity error on current q (see Optional Feature)
cpu_stall  output  1  processor accesses are being ignored (equals load_busy)
load_start  input  1  begin a bulk load (sampled in IDLE only)
load_base  input  ADDR_W  first address of the load
load_len  input  ADDR_W+1  number of words to load
load_data  input  DATA_W  stream word
load_valid  input  1  stream word valid
load_ready  output  1  RAM accepts load_data this cycle
load_busy  output  1  loader active
load_done  output  1  one-cycle pulse when load completes
perr_inject  input  1  invert stored parity on this cycle's write (test hook)

Behaviour:
- Reset values: q=0, q_valid=0, q_perr=0, load_ready=0, load_busy=0, load_done=0; state IDLE; read pipeline flushed; memory contents are NOT cleared.
- Read: rden=1 at edge t captures mem[address]. q/q_valid update at edge t+RD_LAT-1 after capture, i.e. q is valid RD_LAT cycles after the request.
- q holds its last value when no read completes. q_valid=0 on those cycles.
- Back-to-back reads every cycle are fully pipelined at one per cycle.
- Write: wren=1 writes data to mem[address] at the edge.
- Same-cycle rden and wren to the same address returns the OLD word (read-first).
- Loader FSM has three states: IDLE, LOAD, DONE.
- IDLE:
  - load_start=1 with load_len!=0: latch ptr=load_base and cnt=min(load_len, DEPTH), then go to LOAD.
  - load_start=1 with load_len=0: go to DONE with no writes.
- LOAD: load_busy=1, load_ready=1.
  - Each cycle with load_valid&&load_ready: mem[ptr]<=load_data, ptr<=ptr+1 (wraps modulo DEPTH), cnt<=cnt-1.
  - On accepting the last word (cnt==1): go to DONE, load_ready drops the next cycle.
  - load_valid=0 simply stalls; there is no timeout.
- DONE: load_done=1 for exactly one cycle, load_busy=0, load_ready=0, then IDLE.
- load_start is ignored outside IDLE.
- While load_busy=1:
  - processor wren is ignored.
  - rden is ignored (produces no q_valid).
  - cpu_stall=1.
  - Reads already in the pipeline when loading starts still complete.
- Reset mid-load: FSM returns to IDLE next edge, busy/ready/done=0. Words already written remain; unwritten words keep their prior contents.

Optional Feature:
IRAM_PARITY_EN
- Defined:
  - Each word is stored as DATA_W+1 bits with an even-parity bit, on both processor and loader writes.
  - perr_inject=1 during a write stores the inverted parity bit.
  - On read, parity is recomputed; q_perr=1 alongside q_valid when it mismatches, else 0.
  - q_perr obeys the same latency and hold rules as q.
- Undefined:
  - No parity storage; q_perr tied 0.
  - perr_inject is ignored.

Test Plan:
- RD_LAT=1: reset; write 0xA5 to 0x10; rden@0x10 at cycle n -> q=0xA5, q_valid=1 for exactly one cycle at n+1. Repeat with RD_LAT=2 -> result at n+2.
- Same-cycle rden+wren at 0x20 (old 0x11, new 0x22) -> q=0x11; next read of 0x20 -> 0x22.
- Load with load_base=0xFE, load_len=4, data 1,2,3,4, load_valid gapped on the 2nd word -> mem[0xFE]=1, mem[0xFF]=2, mem[0x00]=3, mem[0x01]=4; load_done single pulse after 4th accept; load_busy low afterwards.
- During a load, processor wren@0x40 data=0x77 and rden@0x40 -> mem[0x40] unchanged, no q_valid, cpu_stall=1. load_len=0 start -> load_done pulse next cycle, no writes.
- Reset asserted after 2 of 5 loaded words -> next cycle load_busy=0 and load_ready=0; words 1-2 present, remaining targets unchanged; new load_start accepted.
- With IRAM_PARITY_EN: write 0x3C with perr_inject=1, read back -> q=0x3C, q_perr=1; normal write/read -> q_perr=0. Without the macro -> q_perr always 0.
